// File: rtl/inst_axi_bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI read bridges (instruction and data side).
package inst_axi_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } bridge_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage

// File: rtl/inst_axi_bridge.sv
// Instruction-fetch bridge: turns SRAM-like fetch requests into single-beat AXI reads,
// with at most one transaction in flight.
module inst_axi_bridge #(
  parameter logic [3:0] ARID = 4'h0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  import inst_axi_bridge_pkg::*;

  bridge_state_t state;
  logic [31:0]   addr_q;
  logic [1:0]    size_q;

  // Fetch never writes, and the single-beat read ignores response sidebands.
  logic unused_inputs;
  assign unused_inputs = ^{inst_wr, inst_wdata, rid, rresp, rlast};

  assign inst_addr_ok = (state == S_IDLE) && inst_req;

  assign arid    = ARID;
  assign araddr  = addr_q;
  assign arlen   = LEN_SINGLE;
  assign arsize  = {1'b0, size_q};
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // arvalid/rready are registered alongside the state so each is high only in its own state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      inst_data_ok <= 1'b0;
      inst_rdata   <= 32'h0;
      addr_q       <= 32'h0;
      size_q       <= 2'b00;
    end else begin
      inst_data_ok <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inst_req) begin
            addr_q  <= inst_addr;
            size_q  <= inst_size;
            arvalid <= 1'b1;
            state   <= S_AR;
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            rready       <= 1'b0;
            inst_rdata   <= rdata;
            inst_data_ok <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: begin
          arvalid <= 1'b0;
          rready  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/inst_axi_bridge.md
INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

Interface
REQ-001 Parameter ARID, default 4'h0: fixed AXI ID driven on arid.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 inst_req  input  1  SRAM-like fetch request from the fetch stage.
REQ-005 inst_wr  input  1  write flag; always 0 from fetch, ignored.
REQ-006 inst_size  input  2  transfer size (2'b10 = word).
REQ-007 inst_addr  input  32  fetch byte address.
REQ-008 inst_wdata  input  32  unused, ignored.
REQ-009 inst_addr_ok  output  1  request accepted this cycle.
REQ-010 inst_data_ok  output  1  one-cycle pulse, inst_rdata valid.
REQ-011 inst_rdata  output  32  fetched instruction word.
REQ-012 arid  output  4  read ID.
REQ-013 araddr  output  32  read address.
REQ-014 arlen  output  8  burst length.
REQ-015 arsize  output  3  beat size.
REQ-016 arburst  output  2  burst type.
REQ-017 arlock/arcache/arprot  output  2/4/3  tied 0.
REQ-018 arvalid  output  1;  arready  input  1  AR handshake.
REQ-019 rid  input  4;  rresp  input  2;  rlast  input  1  R sidebands.
REQ-020 rdata  input  32;  rvalid  input  1;  rready  output  1  R handshake.

Function
REQ-021 FSM states IDLE, AR, R; one outstanding transaction at most.
REQ-022 IDLE: inst_addr_ok = inst_req (combinational); on inst_req, latch inst_addr and inst_size, go AR next cycle.
REQ-023 AR and R: inst_addr_ok = 0 regardless of inst_req.
REQ-024 AR: arvalid = 1, araddr = latched address; on arvalid&&arready go R next cycle; otherwise hold AR.
REQ-025 araddr, arsize stay stable while arvalid = 1 and arready = 0.
REQ-026 arlen = 8'd0, arburst = 2'b01, arsize = {1'b0, latched size}, arid = ARID, all constant.
REQ-027 R: rready = 1; on rvalid, register rdata into inst_rdata, go IDLE; rlast, rid, rresp ignored.
REQ-028 inst_data_ok registered: high exactly the cycle after the R handshake, otherwise 0.
REQ-029 When inst_data_ok = 1 the FSM is in IDLE; a same-cycle inst_req gets inst_addr_ok = 1 (back-to-back fetch).
REQ-030 Minimum latency: addr_ok at cycle N, arvalid at N+1, R entered at N+2, data_ok at N+3 (arready and rvalid held 1).
REQ-031 inst_rdata holds its last value until the next completion.
REQ-032 arvalid = 0 outside AR; rready = 0 outside R; an rvalid outside R is not consumed.
REQ-033 rresp error: data still returned with normal data_ok, with no extra signalling.

Reset
REQ-034 rst: state IDLE; inst_data_ok, arvalid, rready = 0; inst_rdata, latched address and latched size = 0.
REQ-035 rst mid-transaction: abandon it immediately, with no data_ok for it; an AXI response arriving later is not consumed.

Structure
REQ-036 The shared package holds the state encodings and the AXI constants BURST_INCR = 2'b01 and SIZE_WORD = 3'b010.
REQ-037 Single flat module with one FSM and no sub-module; the data-side bridge reuses the package.

Verification
REQ-038 Zero-wait: inst_req = 1, addr 0xBFC00000, arready = rvalid = 1, rdata 0x3C1DBFC0 -> addr_ok at cycle 0, araddr 0xBFC00000 at cycle 1, data_ok at cycle 3, inst_rdata = 0x3C1DBFC0.
REQ-039 AR backpressure: arready low for 5 cycles -> arvalid held, araddr stable for all 6 cycles, no data_ok until after the R handshake.
REQ-040 Busy rejection: inst_req held high during AR and R -> inst_addr_ok = 0 throughout, exactly one AR issued.
REQ-041 Back-to-back fetches: new req (0xBFC00004) in the data_ok cycle -> addr_ok = 1 in that cycle, second AR at the next cycle.
REQ-042 Reset in R: rst pulsed while waiting on rvalid -> FSM in IDLE, no data_ok, rready = 0, a late rvalid is ignored.
REQ-043 rresp = 2'b10 with rdata 0xDEADBEEF -> data_ok pulse with inst_rdata = 0xDEADBEEF.
